// File: rtl/row_scan_pkg.sv
// Shared definitions for the row scanning LED matrix controller.
package row_scan_pkg;

   localparam int NROWS = 8;
   localparam int ROW_W = 3;
   localparam int COL_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

endpackage

// File: rtl/row_scan_ctrl_frame_buf.sv
// Double-buffered 8x8 frame store: one bank is displayed (front), the other
// accepts writes (back). A single select flop decides which is which.
module frame_buf
   import row_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [COL_W-1:0] wr_data,
   input  logic             swap_now,
   input  logic [ROW_W-1:0] rd_row,
   output logic [COL_W-1:0] rd_data
);

   logic [COL_W-1:0] bank0 [NROWS];
   logic [COL_W-1:0] bank1 [NROWS];
   logic             sel;   // 0: bank0 is front, 1: bank1 is front

   // Bank select toggles at the frame end that applies a pending swap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sel <= 1'b0;
      else if (swap_now) sel <= ~sel;
   end

   // Writes always land in the back bank chosen by the pre-swap select,
   // so a write on the swap edge ends up in the new front.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NROWS; i++) begin
            bank0[i] <= '0;
            bank1[i] <= '0;
         end
      end else if (wr_en) begin
         if (sel) bank0[wr_row] <= wr_data;
         else     bank1[wr_row] <= wr_data;
      end
   end

   // Front bank read port.
   always_comb begin
      rd_data = sel ? bank1[rd_row] : bank0[rd_row];
   end

endmodule

// File: rtl/row_scan_ctrl.sv
// Row scan controller: blanks, then shows each of 8 rows in turn, driving a
// 3-to-8 active-low row decoder and the column pattern of the current row.
module row_scan_ctrl
   import row_scan_pkg::*;
#(
   parameter int DIV = 1000,
   parameter int BLK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [COL_W-1:0] wr_data,
   input  logic             swap,
   output logic [ROW_W-1:0] addr,
   output logic             nen,
   output logic [COL_W-1:0] col_data,
   output logic             frame_done,
   output logic             swap_pend
);

   localparam int CNT_MAX = (DIV > BLK) ? DIV : BLK;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0]    DIV_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0]    BLK_LAST = CW'(BLK - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NROWS - 1);

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [ROW_W-1:0] addr_n;
   logic             nen_n;
   logic             fd_n;
   logic [COL_W-1:0] col_n;
   logic [COL_W-1:0] rd_data;
   logic             swap_now;

   // A pending swap is applied on the edge that ends the frame_done cycle,
   // which always leads into blanking, so no row ever shows mixed banks.
   assign swap_now = frame_done & swap_pend;

   frame_buf u_buf (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_row   (wr_row),
      .wr_data  (wr_data),
      .swap_now (swap_now),
      .rd_row   (addr_n),
      .rd_data  (rd_data)
   );

   // Next state, counter, row and the registered output values they imply.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      addr_n  = addr;
      if (!run) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
         addr_n  = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_n = ST_BLANK;
               cnt_n   = '0;
            end
            ST_BLANK: begin
               if (cnt == BLK_LAST) begin
                  state_n = ST_SHOW;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            ST_SHOW: begin
               if (cnt == DIV_LAST) begin
                  state_n = ST_BLANK;
                  cnt_n   = '0;
                  addr_n  = addr + ROW_W'(1);
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            default: begin
               state_n = ST_IDLE;
               cnt_n   = '0;
               addr_n  = '0;
            end
         endcase
      end
      nen_n = (state_n != ST_SHOW);
      col_n = (state_n == ST_SHOW) ? rd_data : '0;
      fd_n  = (state_n == ST_SHOW) && (addr_n == ROW_LAST) && (cnt_n == DIV_LAST);
   end

   // State register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         addr       <= '0;
         nen        <= 1'b1;
         col_data   <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         addr       <= addr_n;
         nen        <= nen_n;
         col_data   <= col_n;
         frame_done <= fd_n;
      end
   end

   // Swap request latch; a request coinciding with frame end waits a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) swap_pend <= 1'b0;
      else     swap_pend <= swap | (swap_pend & ~frame_done);
   end

endmodule

// File: doc/row_scan_ctrl.md
ROW_SCAN_CTRL -- requirements
Module: row_scan_ctrl

Interface
REQ-001 Parameter DIV, default 1000: SHOW cycles per row (>=1).
REQ-002 Parameter BLK, default 16: blanking cycles before each row (>=1).
REQ-003 Port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 Port rst, input, 1: reset; asynchronous and active-high.
REQ-005 Port run, input, 1: 1 = scan, 0 = stop to IDLE.
REQ-006 Port wr_en, input, 1: write strobe into back bank.
REQ-007 Port wr_row, input, 3: back-bank row to write.
REQ-008 Port wr_data, input, 8: column pattern for wr_row.
REQ-009 Port swap, input, 1: one-cycle request to exchange front/back banks at frame end.
REQ-010 Port addr, output, 3: row index to downstream 3-to-8 active-low row decoder.
REQ-011 Port nen, output, 1: active-low decoder enable; 1 = all rows off.
REQ-012 Port col_data, output, 8: column pattern of displayed row.
REQ-013 Port frame_done, output, 1: one-cycle pulse at end of row 7 SHOW.
REQ-014 Port swap_pend, output, 1: swap request accepted, not yet applied.

Function
REQ-015 The block SHALL hold two 8x8-bit banks: front (displayed), back (written).
REQ-016 wr_en=1 SHALL write wr_data into back[wr_row] at the clock edge; front is never written directly.
REQ-017 FSM states SHALL be IDLE, BLANK, SHOW.
REQ-018 IDLE: nen=1, addr=0, col_data=0, counter=0; run=1 -> BLANK next cycle.
REQ-019 BLANK: nen=1, col_data=0, addr held; after exactly BLK cycles -> SHOW.
REQ-020 SHOW: nen=0, col_data=front[addr]; after exactly DIV cycles -> BLANK with addr+1 (7 wraps to 0).
REQ-021 Row period SHALL be BLK+DIV cycles; frame period 8*(BLK+DIV) cycles.
REQ-022 addr SHALL change only while nen=1 (never during SHOW), so the decoder never glitches between rows.
REQ-023 All outputs SHALL be registered; no combinational input-to-output path.
REQ-024 frame_done SHALL pulse 1 in the final SHOW cycle of addr=7.
REQ-025 swap=1 SHALL set swap_pend next cycle; repeat swaps while pending are absorbed.
REQ-026 At the frame_done cycle with swap_pend=1, banks SHALL exchange at that edge and swap_pend clear; new front is shown from row 0 of next frame.
REQ-027 swap asserted in the frame_done cycle SHALL be held pending for the following frame end.
REQ-028 wr_en in the swap edge cycle SHALL write the pre-swap back bank (which becomes front).
REQ-029 run=0 in any state SHALL force IDLE next cycle; swap_pend and banks retained.
REQ-030 run held 1 SHALL scan continuously without gaps.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, addr=0, nen=1, col_data=0, frame_done=0, swap_pend=0, counter=0, both banks all-zero.
REQ-032 rst deasserting mid-scan SHALL restart from IDLE; first BLANK begins the cycle after run is sampled 1.

Structure
REQ-033 Package row_scan_pkg SHALL hold state encoding, NROWS=8, ROW_W=3, COL_W=8.
REQ-034 Sub-module frame_buf SHALL implement the two banks, bank-select flop and write/read ports; FSM and counters stay in row_scan_ctrl.

Verification (DIV=4, BLK=2)
REQ-035 Reset then run=1 -> nen=1 for 2 cycles, nen=0 addr=0 for 4 cycles, addr=1 only after nen returns 1.
REQ-036 Full frame -> addr sequence 0..7,0; frame_done single pulse every 48 cycles, in last SHOW cycle of row 7.
REQ-037 Write back[3]=8'hA5, swap mid-frame -> swap_pend=1; rows keep old data until frame end; next frame row 3 col_data=8'hA5, swap_pend=0.
REQ-038 swap in frame_done cycle -> no exchange that frame; exchange at next frame_done.
REQ-039 run=0 during SHOW of row 5 -> next cycle nen=1, addr=0, col_data=0; run=1 restarts at row 0 after 2 BLANK cycles.
REQ-040 rst pulse mid-SHOW -> outputs at reset values same cycle asynchronously; banks read 8'h00.
